// File: rtl/demux_3_reg_if.sv
// Bus bundle for demux_3_reg: input stream, three output channels and the error flag.
// With DEMUX3_ERR_CNT_EN defined the bundle also carries the saturating err_cnt.
interface demux_3_reg_if #(
  parameter int unsigned k = 1
);
  logic [k-1:0] b;
  logic [2:0]   s;
  logic         in_valid;
  logic         in_ready;
  logic [k-1:0] a0;
  logic [k-1:0] a1;
  logic [k-1:0] a2;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic         err;
`ifdef DEMUX3_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  // The demultiplexer itself.
  modport slave (
    input  b, s, in_valid, out_ready,
    output in_ready, a0, a1, a2, out_valid, err
`ifdef DEMUX3_ERR_CNT_EN
    , output err_cnt
`endif
  );

  // Producer and consumers around it.
  modport master (
    output b, s, in_valid, out_ready,
    input  in_ready, a0, a1, a2, out_valid, err
`ifdef DEMUX3_ERR_CNT_EN
    , input err_cnt
`endif
  );
endinterface

// File: rtl/demux_3_reg.sv
// Registered 1-to-3 demultiplexer with one-hot select and one-entry register per channel.
// Optional macro DEMUX3_ERR_CNT_EN adds an 8-bit saturating count of illegal-select words.
module demux_3_reg #(
  parameter int unsigned k = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_3_reg_if.slave   bus
);

  logic [k-1:0] a_q [3];
  logic [k-1:0] a_d [3];
  logic [2:0]   valid_q, valid_d;
  logic [2:0]   free;
  logic [2:0]   load;
  logic         err_q, err_d;
  logic         legal;
  logic         in_ready;
  logic         take;
  logic         illegal_take;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    legal        = (bus.s == 3'b001) || (bus.s == 3'b010) || (bus.s == 3'b100);
    free         = ~valid_q | bus.out_ready;
    // Illegal selects are always swallowed so a bad producer can never wedge the input.
    in_ready     = legal ? |(bus.s & free) : 1'b1;
    take         = bus.in_valid && in_ready;
    illegal_take = take && !legal;
    load         = (take && legal) ? bus.s : 3'b000;
    err_d        = err_q || illegal_take;
    for (int i = 0; i < 3; i++) begin
      // A drain and a load on the same edge keep the channel valid: no bubble.
      valid_d[i] = load[i] || (valid_q[i] && !bus.out_ready[i]);
      a_d[i]     = load[i] ? bus.b : a_q[i];
    end
  end

  // NOTE: the data registers are reset too because their post-reset value of
  // zero is visible on the output ports, not just the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 3; i++) a_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int i = 0; i < 3; i++) a_q[i] <= a_d[i];
    end
  end

`ifdef DEMUX3_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (illegal_take && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.a0        = a_q[0];
  assign bus.a1        = a_q[1];
  assign bus.a2        = a_q[2];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_demux_3_reg.sv
// Self-checking bench for demux_3_reg (k=8): directed steps plus random streaming
// against a queue-based reference model of the three output channels.
module tb_demux_3_reg;

  localparam int unsigned K = 8;

  logic clk;
  logic rst_n;

  demux_3_reg_if #(.k(K)) bus ();

  demux_3_reg #(.k(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a queue of words not yet taken by its consumer.
  logic [K-1:0] chan_q [3][$];
  logic [K-1:0] last_word [3];
  logic         m_err;
  int           m_err_cnt;
  logic         last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K-1:0] a_of(input int i);
    case (i)
      0:       return bus.a0;
      1:       return bus.a1;
      default: return bus.a2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      chan_q[i].delete();
      last_word[i] = '0;
    end
    m_err     = 1'b0;
    m_err_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] exp_valid;
    for (int i = 0; i < 3; i++) exp_valid[i] = (chan_q[i].size() != 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
    chk({tag, "_a0"}, 32'(bus.a0), 32'(last_word[0]));
    chk({tag, "_a1"}, 32'(bus.a1), 32'(last_word[1]));
    chk({tag, "_a2"}, 32'(bus.a2), 32'(last_word[2]));
    chk({tag, "_err"}, 32'(bus.err), 32'(m_err));
`ifdef DEMUX3_ERR_CNT_EN
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(m_err_cnt));
`endif
  endtask

  // One clock cycle: drive after the falling edge, check in_ready and drained words
  // before the rising edge, update the model on it, check registered outputs after it.
  task automatic step(input logic [K-1:0] b, input logic [2:0] s, input logic v,
                      input logic [2:0] rdy);
    int   ch;
    logic legal;
    logic exp_ready;
    @(negedge clk);
    bus.b = b; bus.s = s; bus.in_valid = v; bus.out_ready = rdy;
    #1;
    legal = ($countones(s) == 1);
    ch    = 0;
    for (int i = 0; i < 3; i++) if (s[i]) ch = i;
    exp_ready = legal ? ((chan_q[ch].size() == 0) || rdy[ch]) : 1'b1;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    for (int i = 0; i < 3; i++) begin
      if ((chan_q[i].size() != 0) && rdy[i]) begin
        chk("drain_word", 32'(a_of(i)), 32'(chan_q[i][0]));
        void'(chan_q[i].pop_front());
      end
    end
    last_acc = v && exp_ready;
    @(posedge clk);
    if (last_acc) begin
      if (legal) begin
        chan_q[ch].push_back(b);
        last_word[ch] = b;
      end else begin
        m_err = 1'b1;
        if (m_err_cnt < 255) m_err_cnt++;
      end
    end
    #1;
    check_outputs("cyc");
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int budget;
    int ch;

    // Reset state
    rst_n = 1'b0;
    bus.b = '0; bus.s = 3'b000; bus.in_valid = 1'b0; bus.out_ready = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word to ch1, visible for exactly one cycle
    step(8'h01, 3'b010, 1'b1, 3'b111);
    chk("single_a1", 32'(bus.a1), 32'h01);
    step(8'h00, 3'b000, 1'b0, 3'b111);
    chk("single_gone", 32'(bus.out_valid), 32'h0);

    // Stall and backpressure on ch0
    step(8'h11, 3'b001, 1'b1, 3'b000);
    step(8'h22, 3'b001, 1'b1, 3'b000);
    chk("stall_hold", 32'(bus.a0), 32'h11);
    step(8'h22, 3'b001, 1'b1, 3'b001);
    chk("no_bubble", 32'({bus.out_valid[0], bus.a0}), 32'h122);
    step(8'h00, 3'b000, 1'b0, 3'b001);

    // Channel independence with ch2 stalled
    step(8'h55, 3'b100, 1'b1, 3'b000);
    step(8'h33, 3'b001, 1'b1, 3'b000);
    chk("indep_acc0", 32'(last_acc), 32'd1);
    step(8'h44, 3'b010, 1'b1, 3'b000);
    chk("indep_acc1", 32'(last_acc), 32'd1);
    chk("indep_ch2", 32'({bus.out_valid, bus.a2}), 32'h755);
    step(8'h00, 3'b000, 1'b0, 3'b011);

    // Illegal selects, then saturation of the counter
    step(8'h99, 3'b000, 1'b1, 3'b000);
    step(8'h98, 3'b011, 1'b1, 3'b000);
    step(8'h97, 3'b111, 1'b1, 3'b000);
    chk("illegal_err", 32'(bus.err), 32'd1);
`ifdef DEMUX3_ERR_CNT_EN
    chk("illegal_cnt3", 32'(bus.err_cnt), 32'd3);
`endif
    for (int n = 3; n < 300; n++) begin
      logic [2:0] bad;
      bad = 3'($urandom_range(0, 7));
      if ($countones(bad) == 1) bad = 3'b000;
      step(8'($urandom), bad, 1'b1, 3'b000);
    end
`ifdef DEMUX3_ERR_CNT_EN
    chk("illegal_cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif
    step(8'h00, 3'b000, 1'b0, 3'b111);

    // Random streaming of 100 accepted legal words
    accepted = 0;
    budget   = 0;
    while (accepted < 100 && budget < 2000) begin
      ch = $urandom_range(0, 2);
      step(8'($urandom), 3'b001 << ch, 1'($urandom_range(0, 3) != 0), 3'($urandom));
      if (last_acc) accepted++;
      budget++;
    end
    chk("stream_count", 32'(accepted), 32'd100);
    repeat (2) step(8'h00, 3'b000, 1'b0, 3'b111);
    chk("stream_empty", 32'(chan_q[0].size() + chan_q[1].size() + chan_q[2].size()), 32'd0);

    // Reset mid-stream with all channels holding words
    step(8'hA0, 3'b001, 1'b1, 3'b000);
    step(8'hA1, 3'b010, 1'b1, 3'b000);
    step(8'hA2, 3'b100, 1'b1, 3'b000);
    chk("full_before_rst", 32'(bus.out_valid), 32'h7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h5A, 3'b100, 1'b1, 3'b111);
    step(8'h00, 3'b000, 1'b0, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
